cordic_stream_ctrl: RTL and testbench

CORDIC_STREAM_CTRL -- requirements
Module: cordic_stream_ctrl

---
 rtl/cordic_stream_ctrl.sv | 115 +++++++++++
 tb/tb_cordic_stream_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_stream_ctrl.sv
// Credit-based stream wrapper around a fixed-latency, never-stalling CORDIC pipeline.
// Results land in a small circular FIFO; credits (in-flight + buffered) throttle in_ready.
module cordic_stream_ctrl #(
  parameter int LATENCY = 16,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_data,
  output logic [31:0]                  cordic_in,
  input  logic [31:0]                  cordic_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_data,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  // Handshakes: a word moves when valid && ready at a rising edge; the source
  // holds data stable while valid && !ready, and ready never depends on valid.
  logic             accept;
  logic             push;
  logic             pop;

  logic [LATENCY:0] tag_q,      tag_d;
  logic [OCC_W-1:0] inflight_q, inflight_d;
  logic [OCC_W-1:0] count_q,    count_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [31:0]      cordic_in_q, cordic_in_d;
  logic [OCC_W-1:0] occ_sum;
  logic [31:0]      mem_q [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Credits come from registered counts only, so a pop frees a slot one cycle later.
  assign occ_sum   = inflight_q + count_q;
  assign in_ready  = rst && (occ_sum < DEPTH_C);
  assign occupancy = rst ? occ_sum : '0;
  assign out_valid = rst && (count_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign cordic_in = cordic_in_q;

  assign accept = in_valid && in_ready;
  assign push   = tag_q[LATENCY];
  assign pop    = out_valid && out_ready;

  always_comb begin
    tag_d       = {tag_q[LATENCY-1:0], accept};
    inflight_d  = inflight_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cordic_in_d = cordic_in_q;

    if (accept) cordic_in_d = in_data;

    case ({accept, push})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q       <= '0;
      inflight_q  <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cordic_in_q <= '0;
    end else begin
      tag_q       <= tag_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cordic_in_q <= cordic_in_d;
    end
  end

  // Storage needs no reset: the count alone decides which words are meaningful.
  always_ff @(posedge clk) begin
    if (rst && push) mem_q[wr_ptr_q] <= cordic_out;
  end

`ifndef SYNTHESIS
  push_when_full_a: assert property (@(posedge clk) disable iff (!rst)
    !(push && (count_q == DEPTH_C)))
    else $error("cordic_stream_ctrl: push into full result FIFO");

  occupancy_bound_a: assert property (@(posedge clk) disable iff (!rst)
    occ_sum <= DEPTH_C)
    else $error("cordic_stream_ctrl: occupancy above DEPTH");
`endif

endmodule

// File: tb/tb_cordic_stream_ctrl.sv
// Directed bench for cordic_stream_ctrl with a 16-stage delay line standing in for the CORDIC.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_cordic_stream_ctrl;

  localparam int LATENCY = 16;
  localparam int DEPTH   = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] cordic_in;
  logic [31:0] cordic_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  occupancy;

  int n_cmp;
  int n_err;
  logic [31:0] exp_q[$];

  cordic_stream_ctrl #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cordic_in(cordic_in), .cordic_out(cordic_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] x);
    return {x[15:0], x[31:16]} ^ 32'h5A5A_5A5A;
  endfunction

  logic [31:0] pipe_q [LATENCY];
  always_ff @(posedge clk) begin
    pipe_q[0] <= cordic_in;
    for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
  end
  assign cordic_out = model(pipe_q[LATENCY-1]);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    n_cmp++; if (cordic_in !== 32'h0) begin n_err++; $display("FAIL reset_cordic_in: got %h want 0", cordic_in); end
    rst = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL first_cycle_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h0000_4000;
    step();
    in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
    n_cmp++; if (cordic_in !== 32'h0000_4000) begin n_err++; $display("FAIL single_cordic_in: got %h want 00004000", cordic_in); end
    for (int e = 1; e <= LATENCY; e++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: edge %0d got %b want 0", e, out_valid); end
    end
    n_cmp++; if (cordic_in !== 32'h0000_4000) begin n_err++; $display("FAIL single_cordic_hold: got %h want 00004000", cordic_in); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid_edge17: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 32'h1A5A_5A5A) begin n_err++; $display("FAIL single_data: got %h want 1a5a5a5a", out_data); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_drop: got %b want 0", out_valid); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL single_occupancy: got %0d want 0", occupancy); end
  endtask

  task automatic test_burst_drain();
    logic [31:0] s [6];
    logic [31:0] held;
    int k;
    for (int i = 0; i < 6; i++) s[i] = 32'h0000_1001 + i;
    k = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = s[k];
      #0;
      n_cmp++; if (in_ready !== (i < DEPTH)) begin n_err++; $display("FAIL burst_ready: cycle %0d got %b want %b", i, in_ready, (i < DEPTH)); end
      if (in_ready) k++;
      step();
    end
    n_cmp++; if (k !== 4) begin n_err++; $display("FAIL burst_accepted: got %0d want 4", k); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL burst_blocked: cycle %0d got %b want 0", i, in_ready); end
      step();
    end
    n_cmp++; if (occupancy !== 3'd4) begin n_err++; $display("FAIL burst_occupancy: got %0d want 4", occupancy); end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL burst_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== model(s[0])) begin n_err++; $display("FAIL burst_head: got %h want %h", out_data, model(s[0])); end
    held = out_data;
    step();
    n_cmp++; if (out_data !== held) begin n_err++; $display("FAIL burst_head_stable: got %h want %h", out_data, held); end

    // Drain: sample 5 is still being offered
    out_ready = 1'b1;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL drain_ready_back: got %b want 1", in_ready); end
    n_cmp++; if (out_data !== model(s[1])) begin n_err++; $display("FAIL drain_pop2: got %h want %h", out_data, model(s[1])); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (cordic_in !== s[4]) begin n_err++; $display("FAIL drain_s5_accept: got %h want %h", cordic_in, s[4]); end
    n_cmp++; if (out_data !== model(s[2])) begin n_err++; $display("FAIL drain_pop3: got %h want %h", out_data, model(s[2])); end
    step();
    n_cmp++; if (out_data !== model(s[3])) begin n_err++; $display("FAIL drain_pop4: got %h want %h", out_data, model(s[3])); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", out_valid); end
    for (int e = 3; e < LATENCY + 1; e++) step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_s5_early: got %b want 0", out_valid); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL drain_s5_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== model(s[4])) begin n_err++; $display("FAIL drain_s5_data: got %h want %h", out_data, model(s[4])); end
    step();
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL drain_final_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_stream();
    logic [31:0] next;
    int n_res;
    next = 32'h0100_0000;
    n_res = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      in_valid = (c < 60);
      in_data = next;
      #0;
      if (occupancy > 3'd4) begin
        n_cmp++; n_err++; $display("FAIL stream_occ_bound: got %0d want <=4", occupancy);
      end
      if (out_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL stream_extra: got %h want none", out_data);
        end else begin
          if (out_data !== exp_q[0]) begin n_err++; $display("FAIL stream_order: got %h want %h", out_data, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        n_res++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(next));
        next = next + 1;
      end
      step();
    end
    in_valid = 1'b0;
    n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL stream_drops: got %0d left want 0", exp_q.size()); end
    n_cmp++; if (n_res < 12) begin n_err++; $display("FAIL stream_throughput: got %0d results want >=12", n_res); end
    exp_q.delete();
  endtask

  task automatic test_simul_push_pop();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h0000_AAAA;
    step();
    in_data = 32'h0000_BBBB;
    step();
    in_valid = 1'b0;
    for (int e = 2; e <= LATENCY + 1; e++) step();
    n_cmp++; if (out_data !== model(32'h0000_AAAA)) begin n_err++; $display("FAIL simul_head_a: got %h want %h", out_data, model(32'h0000_AAAA)); end
    n_cmp++; if (occupancy !== 3'd2) begin n_err++; $display("FAIL simul_occ_before: got %0d want 2", occupancy); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL simul_valid: got %b want 1", out_valid); end
    n_cmp++; if (occupancy !== 3'd1) begin n_err++; $display("FAIL simul_count: got %0d want 1", occupancy); end
    n_cmp++; if (out_data !== model(32'h0000_BBBB)) begin n_err++; $display("FAIL simul_head_b: got %h want %h", out_data, model(32'h0000_BBBB)); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL simul_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    int bad;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'h0000_C000 + i;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b0;
    #0;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready: got %b want 0", in_ready); end
    n_cmp++; if (occupancy !== 3'd0) begin n_err++; $display("FAIL midrst_occ_low: got %0d want 0", occupancy); end
    step();
    rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (out_valid !== 1'b0 || occupancy !== 3'd0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL midrst_discard: got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_burst_drain();
    test_stream();
    test_simul_push_pop();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
